step_pulse_gen: RTL and testbench
=================================

// Module: step_pulse_gen
// PURPOSE
//   Synthetic step source for the activity tracker. Turns a selected activity
//   MODE into a train of step pulses at an exact steps-per-second rate.
//   Sits directly upstream of the step counter/statistics stage, which counts
//   rising edges of PULSE and uses SEC_TICK/RATE for time-based statistics.
//   Rate generation uses a phase accumulator (no divider), giving exactly RATE
//   pulses per second.
// PARAMETERS
//   CLK_HZ    100_000_000  clock cycles per second (benches use 1000)
//   PULSE_W   2            PULSE high time in cycles; must be < CLK_HZ/128
//   WALK_RATE 32           steps/s, MODE=00
//   JOG_RATE  64           steps/s, MODE=01
//   RUN_RATE  128          steps/s, MODE=10
// PORTS
//   CLK       in   1  system clock, all logic on posedge
//   RESET     in   1  synchronous, active-high reset
//   START     in   1  level; 1 = generate, 0 = idle/clear
//   MODE      in   2  00 walk, 01 jog, 10 run, 11 hybrid
//   PULSE     out  1  step pulse, high PULSE_W cycles per step (registered)
//   SEC_TICK  out  1  one-cycle strobe at each completed second while running
//   RATE      out  8  steps/s currently in force (0 when idle)
// BEHAVIOUR
//   Reset: PULSE=0, SEC_TICK=0, RATE=0, acc=0, sec_cnt=0, hyb_idx=0,
//     pw_cnt=0, running=0. RESET has priority over START.
//   running <= START each cycle. START=0: next cycle PULSE=0, RATE=0;
//     acc, sec_cnt, hyb_idx, pw_cnt cleared.
//   Rate latch: on the first running cycle and on each cycle where
//     sec_cnt wraps, MODE is sampled and RATE is loaded. MODE changes
//     within a second are ignored until the next boundary.
//   Hybrid table (steps/s, per elapsed second from 1): 20,33,66,27,70,30,19,
//     30,33; second 10 onward: 69. hyb_idx saturates at 9.
//     hyb_idx restarts at 0 on START rise and on any boundary where the
//     latched MODE newly becomes 11.
//   sec_cnt: 0..CLK_HZ-1 while running. At wrap: SEC_TICK=1 for one cycle,
//     acc cleared to 0, and hyb_idx advances if hybrid.
//   Accumulator: width clog2(CLK_HZ+128). Each running cycle:
//     if acc+RATE >= CLK_HZ, set acc <= acc+RATE-CLK_HZ and fire a step event;
//     otherwise acc <= acc+RATE.
//     A step event loads pw_cnt=PULSE_W. PULSE is 1 while pw_cnt != 0, and
//     pw_cnt decrements each cycle.
//   Guarantee: exactly RATE rising PULSE edges per second. PULSE is low at
//     least 1 cycle between steps. The first edge of a second comes
//     ceil(CLK_HZ/RATE) cycles after the boundary.
//   PULSE registered: rises 1 cycle after its step event.
//   START drop mid-pulse truncates PULSE next cycle (no partial resume).
//   RATE change at a boundary takes effect from that boundary's accumulation.
// TESTING (CLK_HZ=1000, PULSE_W=2)
//   1 RESET=1 with START=1, MODE=10 for 5 cycles -> PULSE=0, RATE=0,
//     SEC_TICK=0 throughout.
//   2 START=1, MODE=00 for 3000 cycles -> 96 PULSE rising edges, 32 per
//     1000-cycle window, 3 SEC_TICKs, RATE=32. First rise at cycle 32 or 33.
//   3 MODE=10 -> 128 edges/s, each high exactly 2 cycles, low >= 5 cycles.
//   4 MODE=11 for 11 s -> per-second edge counts 20,33,66,27,70,30,19,30,33,
//     69,69.
//   5 MODE 00->01 at cycle 500 of a second -> that second 32 edges, next 64;
//     RATE changes only on the SEC_TICK cycle.
//   6 START 1->0 mid-pulse at cycle 1700, then back to 1 -> PULSE=0 next
//     cycle. Restart: hybrid from entry 0, full second to first SEC_TICK.

Source files
------------

// File: rtl/step_pulse_gen_if.sv
// Control and observation bundle for the synthetic step source.
interface step_pulse_gen_if;
  logic       start;
  logic [1:0] mode;
  logic       pulse;
  logic       sec_tick;
  logic [7:0] rate;

  modport master (
    output start,
    output mode,
    input  pulse,
    input  sec_tick,
    input  rate
  );

  modport slave (
    input  start,
    input  mode,
    output pulse,
    output sec_tick,
    output rate
  );
endinterface

// File: rtl/step_pulse_gen.sv
// Step pulse train at an exact steps-per-second rate chosen by activity mode.
// A phase accumulator restarted every second yields exactly RATE steps per second.
module step_pulse_gen #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned PULSE_W   = 2,
  parameter int unsigned WALK_RATE = 32,
  parameter int unsigned JOG_RATE  = 64,
  parameter int unsigned RUN_RATE  = 128
) (
  input  logic            clk,
  input  logic            reset,
  step_pulse_gen_if.slave bus
);

  localparam int unsigned AW = $clog2(CLK_HZ + 128);
  localparam int unsigned SW = $clog2(CLK_HZ);
  localparam int unsigned PW = $clog2(PULSE_W + 1);
  localparam logic [AW-1:0] CLK_A    = AW'(CLK_HZ);
  localparam logic [SW-1:0] SEC_LAST = SW'(CLK_HZ - 1);
  localparam logic [3:0]    HYB_LAST = 4'd9;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] acc, acc_nxt;
  logic [SW-1:0] sec_cnt, sec_cnt_nxt;
  logic [3:0]    hyb_idx, hyb_idx_nxt;
  logic [1:0]    mode_lat, mode_lat_nxt;
  logic [PW-1:0] pw_cnt, pw_cnt_nxt;
  logic          pulse_nxt;
  logic          sec_tick_nxt;
  logic [7:0]    rate_nxt;
  logic          boundary;
  logic          step;
  logic [AW-1:0] sum;

  // Steps/s for each elapsed hybrid second; the last entry holds from second 10 on.
  function automatic logic [7:0] hyb_rate(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'd20;
      4'd1:    return 8'd33;
      4'd2:    return 8'd66;
      4'd3:    return 8'd27;
      4'd4:    return 8'd70;
      4'd5:    return 8'd30;
      4'd6:    return 8'd19;
      4'd7:    return 8'd30;
      4'd8:    return 8'd33;
      default: return 8'd69;
    endcase
  endfunction

  function automatic logic [7:0] mode_rate(input logic [1:0] m, input logic [3:0] idx);
    case (m)
      2'b00:   return 8'(WALK_RATE);
      2'b01:   return 8'(JOG_RATE);
      2'b10:   return 8'(RUN_RATE);
      default: return hyb_rate(idx);
    endcase
  endfunction

  // Next-state, second boundary, rate latch and accumulator step decision.
  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    sec_cnt_nxt  = sec_cnt;
    hyb_idx_nxt  = hyb_idx;
    mode_lat_nxt = mode_lat;
    pw_cnt_nxt   = pw_cnt;
    sec_tick_nxt = 1'b0;
    rate_nxt     = bus.rate;
    boundary     = 1'b0;
    step         = 1'b0;
    sum          = {AW{1'b0}};

    if (!bus.start) begin
      state_nxt    = IDLE;
      acc_nxt      = {AW{1'b0}};
      sec_cnt_nxt  = {SW{1'b0}};
      hyb_idx_nxt  = 4'd0;
      mode_lat_nxt = 2'b00;
      pw_cnt_nxt   = {PW{1'b0}};
      rate_nxt     = 8'd0;
    end else begin
      state_nxt = RUN;
      boundary  = (state == IDLE) || (sec_cnt == SEC_LAST);
      if (boundary) begin
        sec_cnt_nxt  = {SW{1'b0}};
        sec_tick_nxt = (state == RUN);
        if (bus.mode == 2'b11) begin
          if ((state == RUN) && (mode_lat == 2'b11))
            hyb_idx_nxt = (hyb_idx == HYB_LAST) ? hyb_idx : hyb_idx + 4'd1;
          else
            hyb_idx_nxt = 4'd0;
        end
        mode_lat_nxt = bus.mode;
        rate_nxt     = mode_rate(bus.mode, hyb_idx_nxt);
      end else begin
        sec_cnt_nxt = sec_cnt + SW'(1);
      end

      // The boundary cycle is the first accumulation of the new second.
      sum     = (boundary ? {AW{1'b0}} : acc) + AW'(rate_nxt);
      step    = (sum >= CLK_A);
      acc_nxt = step ? (sum - CLK_A) : sum;

      if (step)
        pw_cnt_nxt = PW'(PULSE_W);
      else if (pw_cnt != {PW{1'b0}})
        pw_cnt_nxt = pw_cnt - PW'(1);
    end

    pulse_nxt = (pw_cnt_nxt != {PW{1'b0}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      acc          <= {AW{1'b0}};
      sec_cnt      <= {SW{1'b0}};
      hyb_idx      <= 4'd0;
      mode_lat     <= 2'b00;
      pw_cnt       <= {PW{1'b0}};
      bus.pulse    <= 1'b0;
      bus.sec_tick <= 1'b0;
      bus.rate     <= 8'd0;
    end else begin
      state        <= state_nxt;
      acc          <= acc_nxt;
      sec_cnt      <= sec_cnt_nxt;
      hyb_idx      <= hyb_idx_nxt;
      mode_lat     <= mode_lat_nxt;
      pw_cnt       <= pw_cnt_nxt;
      bus.pulse    <= pulse_nxt;
      bus.sec_tick <= sec_tick_nxt;
      bus.rate     <= rate_nxt;
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: per-cycle comparison against a per-second arithmetic
// model, directed scenarios with literal expectations, then randomized traffic.
module tb_step_pulse_gen;
  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned PULSE_W = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  step_pulse_gen_if bus ();

  step_pulse_gen #(.CLK_HZ(CLK_HZ), .PULSE_W(PULSE_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: step k (1-based) of a second lands on the accumulation where
  // floor(k*CLK_HZ/R) is crossed, i.e. floor(n*R/CLK_HZ) increments at n.
  int hyb_tab[10]  = '{20, 33, 66, 27, 70, 30, 19, 30, 33, 69};
  int base_rate[3] = '{32, 64, 128};
  int n_edge = 0;
  int m_run = 0, m_t = 0, m_rate = 0, m_mode_lat = 0, m_hidx = 0, m_pos = 0;
  int m_last_ev = -100;
  int exp_pulse = 0, exp_tick = 0, exp_rate = 0;

  always @(posedge clk) begin
    n_edge++;
    if (reset || !bus.start) begin
      m_run = 0; m_t = 0; m_rate = 0; m_mode_lat = 0; m_hidx = 0;
      m_last_ev = -100; exp_tick = 0;
    end else begin
      m_t   = m_run ? m_t + 1 : 0;
      m_pos = m_t % CLK_HZ;
      exp_tick = 0;
      if (m_pos == 0) begin
        exp_tick = (m_t != 0) ? 1 : 0;
        if (int'(bus.mode) == 3) begin
          if (m_t != 0 && m_mode_lat == 3) m_hidx = (m_hidx < 9) ? m_hidx + 1 : 9;
          else m_hidx = 0;
          m_rate = hyb_tab[m_hidx];
        end else begin
          m_rate = base_rate[int'(bus.mode)];
        end
        m_mode_lat = int'(bus.mode);
      end
      if (((m_pos + 1) * m_rate) / CLK_HZ > (m_pos * m_rate) / CLK_HZ) m_last_ev = n_edge;
      m_run = 1;
    end
    exp_pulse = (m_run != 0 && (n_edge - m_last_ev) < PULSE_W) ? 1 : 0;
    exp_rate  = m_run ? m_rate : 0;
  end

  // Per-cycle comparison plus per-second edge counts and pulse shape monitors.
  int win_q[$];
  int win_cnt = 0, high_len = 0, low_len = 0, prev_rate = 0, prev_run = 0;
  bit prev_pulse = 1'b0, low_valid = 1'b0, rise, fall;

  always @(negedge clk) begin
    if (n_edge > 0) begin
      check("pulse", int'(bus.pulse), exp_pulse);
      check("sec_tick", int'(bus.sec_tick), exp_tick);
      check("rate", int'(bus.rate), exp_rate);

      rise = bus.pulse && !prev_pulse;
      fall = !bus.pulse && prev_pulse;

      if (!m_run) win_cnt = 0;
      else if (bus.sec_tick) begin
        win_q.push_back(win_cnt);
        win_cnt = rise ? 1 : 0;
      end else if (rise) win_cnt++;

      if (m_run && prev_run && int'(bus.rate) != prev_rate)
        check("rate_change_on_tick", int'(bus.sec_tick), 1);

      if (fall) begin
        if (m_run) check("high_width", high_len, PULSE_W);
        high_len  = 0;
        low_len   = 0;
        low_valid = (m_run != 0);
      end
      if (rise && m_run && low_valid && m_rate == 128)
        check("run_low_gap_ge5", (low_len >= 5) ? 1 : 0, 1);
      if (!m_run) low_valid = 1'b0;
      if (bus.pulse) high_len++; else low_len++;

      prev_pulse = bus.pulse;
      prev_rate  = int'(bus.rate);
      prev_run   = m_run;
    end
  end

  task automatic wait_windows(input int target);
    int guard = 0;
    while (win_q.size() < target && guard < 13000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (win_q.size() < target) begin
      checks++;
      failures++;
      $display("FAIL window_timeout: got %0d windows expected %0d", win_q.size(), target);
    end
  endtask

  function automatic int win_at(input int idx);
    return (idx < win_q.size()) ? win_q[idx] : -1;
  endfunction

  int exp_h[11] = '{20, 33, 66, 27, 70, 30, 19, 30, 33, 69, 69};
  int base, n, total;

  initial begin
    reset = 1'b1;
    bus.start = 1'b1;
    bus.mode  = 2'b10;

    // Reset dominates an asserted start.
    repeat (5) begin
      @(posedge clk); #1;
      check("reset_pulse", int'(bus.pulse), 0);
      check("reset_rate", int'(bus.rate), 0);
      check("reset_tick", int'(bus.sec_tick), 0);
    end

    // Walk: first edge timing and three full seconds.
    reset = 1'b0;
    bus.mode = 2'b00;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.pulse && n < 100);
    check("first_rise_cycle", n, 32);
    check("walk_rate", int'(bus.rate), 32);
    base = win_q.size();
    wait_windows(base + 3);
    total = 0;
    for (int i = 0; i < 3; i++) begin
      check("walk_per_sec", win_at(base + i), 32);
      total += win_at(base + i);
    end
    check("walk_total_3s", total, 96);

    // Run: mode change mid-second is deferred to the boundary.
    bus.mode = 2'b10;
    base = win_q.size();
    wait_windows(base + 2);
    check("run_deferred_sec", win_at(base), 32);
    check("run_per_sec", win_at(base + 1), 128);
    check("run_rate", int'(bus.rate), 128);

    // Hybrid sequence across eleven seconds.
    bus.mode = 2'b11;
    base = win_q.size();
    wait_windows(base + 1);
    base = win_q.size();
    wait_windows(base + 11);
    for (int i = 0; i < 11; i++) check("hybrid_per_sec", win_at(base + i), exp_h[i]);

    // Walk -> jog switched halfway through a second.
    bus.mode = 2'b00;
    base = win_q.size();
    wait_windows(base + 1);
    repeat (499) begin @(posedge clk); #1; end
    bus.mode = 2'b01;
    base = win_q.size();
    wait_windows(base + 2);
    check("walk_sec_before_jog", win_at(base), 32);
    check("jog_per_sec", win_at(base + 1), 64);

    // Start drop mid-pulse, then restart into hybrid from entry 0.
    bus.mode = 2'b11;
    base = win_q.size();
    wait_windows(base + 2);
    check("hybrid_second2_rate", int'(bus.rate), 33);
    n = 0;
    while (!bus.pulse && n < 300) begin @(posedge clk); #1; n++; end
    check("pulse_seen_before_drop", int'(bus.pulse), 1);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("drop_pulse", int'(bus.pulse), 0);
    check("drop_rate", int'(bus.rate), 0);
    repeat (3) begin @(posedge clk); #1; end
    bus.start = 1'b1;
    @(posedge clk); #1;
    n = 1;
    check("restart_rate", int'(bus.rate), 20);
    while (!bus.sec_tick && n < 1100) begin @(posedge clk); #1; n++; end
    check("restart_first_tick", n, 1001);
    @(posedge clk); #1;
    check("restart_first_sec", win_at(win_q.size() - 1), 20);

    // Randomized mode changes, start drops and occasional resets.
    for (int i = 0; i < 14000; i++) begin
      if ($urandom_range(0, 199) == 0) bus.mode = 2'($urandom_range(0, 3));
      if (bus.start && $urandom_range(0, 2499) == 0) bus.start = 1'b0;
      else if (!bus.start && $urandom_range(0, 3) == 0) bus.start = 1'b1;
      reset = ($urandom_range(0, 3999) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
